// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Truncated clock cycles per serial bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_serializer_if.sv
// Byte stream handshake between upstream register logic and the UART TX FIFO.
interface uart_tx_fifo_serializer_if;
    import uart_pkg::*;

    logic                      s_valid;
    logic [UART_DATA_BITS-1:0] s_data;
    logic                      s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO; rdata is valid whenever empty is low.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] wdata,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
        $error("uart_byte_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wptr;
    logic [AW-1:0]             r_rptr;
    logic [LW-1:0]             r_level;
    logic                      w_push;
    logic                      w_pop;

    // Guards keep a full push or empty pop from corrupting pointers.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);

endmodule

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1/8N2 serializer, LSB first, idle-high line.
module uart_tx_fifo_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    uart_tx_fifo_serializer_if.slave     s_if,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned CLKS_PER_BIT = unsigned'(clks_per_bit(int'(CLK_FREQ_HZ), int'(BAUD_RATE)));
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(UART_DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_STOP  = 2'(STOP);

    if (CLKS_PER_BIT < 2) begin : g_err_baud
        $error("uart_tx_fifo_serializer: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_err_stop
        $error("uart_tx_fifo_serializer: STOP_BITS must be 1 or 2");
    end

    logic [1:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_W-1:0]          r_bit_idx;
    logic                      r_stop_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;

    logic [1:0]                w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [BIT_W-1:0]          w_bit_nxt;
    logic                      w_stop_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_tx_nxt;
    logic                      w_cnt_done;

    logic                      w_push;
    logic                      w_pop;
    logic [UART_DATA_BITS-1:0] w_rdata;
    logic [LVL_W-1:0]          w_level;
    logic                      w_full;
    logic                      w_empty;

    // Ready decodes only the registered level, so s_valid never reaches s_ready.
    assign s_if.s_ready = !w_full;
    assign w_push       = s_if.s_valid && !w_full;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (s_if.s_data),
        .rdata (w_rdata),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_cnt_done = (r_cnt == '0);

    // Next-state logic; a pop happens only on entry to START.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_stop_nxt  = r_stop_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_shift_nxt = w_rdata;
                end
            end
            ST_START: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = CNT_RELOAD;
                    w_shift_nxt = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_nxt = ST_STOP;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_bit_nxt = r_bit_idx + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_cnt_done) begin
                    if (r_stop_idx == STOP_LAST) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_START;
                            w_cnt_nxt   = CNT_RELOAD;
                            w_shift_nxt = w_rdata;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_stop_nxt = r_stop_idx + 1'b1;
                        w_cnt_nxt  = CNT_RELOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == ST_DATA) begin
            w_tx_nxt = w_shift_nxt[0];
        end else begin
            w_tx_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_stop_idx <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE) || (w_level != '0);
    assign fifo_level = w_level;

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: scoreboarded line decoder plus cycle-exact waveform checks.
module tb_uart_tx_fifo_serializer;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [3:0] lvl_a, lvl_b;

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_fifo_serializer_if a_if ();
    uart_tx_fifo_serializer_if b_if ();

    uart_tx_fifo_serializer #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD_RATE (BAUD), .FIFO_DEPTH (DEPTH), .STOP_BITS (1)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .s_if (a_if), .tx (tx_a), .busy (busy_a), .fifo_level (lvl_a)
    );

    uart_tx_fifo_serializer #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD_RATE (BAUD), .FIFO_DEPTH (DEPTH), .STOP_BITS (2)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .s_if (b_if), .tx (tx_b), .busy (busy_b), .fifo_level (lvl_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Record every accepted byte on the A stream as an expected decoded byte.
    always @(negedge clk) begin
        if (rst_n && a_if.s_valid && a_if.s_ready) sb.push_back(a_if.s_data);
    end

    task automatic dec_wait(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Line decoder on tx_a: detect falling edge, sample mid-bit.
    initial begin : decoder
        logic       prev, ab, s0, sp;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx_a) begin
                starts.push_back(cyc);
                ab = 1'b0;
                d  = '0;
                dec_wait(5, ab);
                s0 = tx_a;
                for (int i = 0; i < 8; i++) begin
                    dec_wait(10, ab);
                    d[i] = tx_a;
                end
                dec_wait(10, ab);
                sp = tx_a;
                if (!ab) begin
                    check_eq("dec_start_bit", 32'(s0), 32'(0));
                    check_eq("dec_stop_bit", 32'(sp), 32'(1));
                    check_eq("dec_expected_pending", 32'(sb.size() != 0), 32'(1));
                    if (sb.size() != 0) check_eq("dec_data", 32'(d), 32'(sb.pop_front()));
                end
            end
            prev = tx_a;
        end
    end

    task automatic push_byte(input int sel, input logic [7:0] b, output int n);
        logic rdy;
        n = -1;
        if (sel == 0) begin a_if.s_valid = 1'b1; a_if.s_data = b; end
        else          begin b_if.s_valid = 1'b1; b_if.s_data = b; end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? a_if.s_ready : b_if.s_ready;
            if (rdy) begin
                n = cyc + 1;
                break;
            end
        end
        check_eq("push_accepted", 32'(n >= 0), 32'(1));
        @(posedge clk);
        #1;
        if (sel == 0) a_if.s_valid = 1'b0;
        else          b_if.s_valid = 1'b0;
    endtask

    // Compare tx against the ideal frame of byte b whose start bit begins at edge n+1.
    task automatic check_frame(input int sel, input logic [7:0] b, input int n, input int nstop);
        int   len;
        logic t, bz, e;
        len = 10 * (9 + nstop);
        while (cyc < n + 1) @(negedge clk);
        for (int k = 0; k < len; k++) begin
            t  = (sel == 0) ? tx_a : tx_b;
            bz = (sel == 0) ? busy_a : busy_b;
            if (k < 10)      e = 1'b0;
            else if (k < 90) e = b[(k - 10) / 10];
            else             e = 1'b1;
            check_eq($sformatf("frame_tx k=%0d", k), 32'(t), 32'(e));
            if (k == len - 1) check_eq("frame_busy_last", 32'(bz), 32'(1));
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int sel, input int budget, input string tag);
        logic b;
        b = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            b = (sel == 0) ? busy_a : busy_b;
            if (!b) break;
        end
        check_eq(tag, 32'(b), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int   n, m, n0, nlast, sent, acc, minl, lows, bhigh;
        logic a;

        a_if.s_valid = 1'b0; a_if.s_data = '0;
        b_if.s_valid = 1'b0; b_if.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_a", 32'(tx_a), 32'(1));
        check_eq("rst_busy_a", 32'(busy_a), 32'(0));
        check_eq("rst_level_a", 32'(lvl_a), 32'(0));
        check_eq("rst_ready_a", 32'(a_if.s_ready), 32'(1));
        check_eq("rst_tx_b", 32'(tx_b), 32'(1));
        check_eq("rst_busy_b", 32'(busy_b), 32'(0));
        check_eq("rst_level_b", 32'(lvl_b), 32'(0));
        check_eq("rst_ready_b", 32'(b_if.s_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: exact waveform and busy release at N+101.
        push_byte(0, 8'h55, n);
        check_frame(0, 8'h55, n, 1);
        check_eq("single_busy_fall", 32'(busy_a), 32'(0));
        check_eq("single_fall_cycle", 32'(cyc - n), 32'(101));
        @(posedge clk);
        #1;
        check_eq("single_decoded", 32'(sb.size()), 32'(0));

        // Burst of 9 bytes with s_valid held.
        starts.delete();
        a_if.s_valid = 1'b1; a_if.s_data = 8'h00;
        sent = 0; n0 = -1; nlast = -1;
        for (int i = 0; i < 100 && sent < 9; i++) begin
            @(negedge clk);
            a = a_if.s_ready;
            @(posedge clk);
            #1;
            if (a) begin
                if (sent == 0) n0 = cyc;
                nlast = cyc;
                sent++;
                if (sent == 9) a_if.s_valid = 1'b0;
                else           a_if.s_data = 8'(sent);
            end
        end
        a_if.s_valid = 1'b0;
        check_eq("burst_accepted", 32'(sent), 32'(9));
        check_eq("burst_accept_span", 32'(nlast - n0), 32'(8));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        check_eq("burst_total_len", 32'(cyc - n0), 32'(901));
        check_eq("burst_frames", 32'(starts.size()), 32'(9));
        check_eq("burst_first_start", 32'(starts.size() > 0 ? starts[0] - n0 : -1), 32'(1));
        for (int i = 1; i < starts.size(); i++)
            check_eq($sformatf("burst_gap %0d", i), 32'(starts[i] - starts[i-1]), 32'(100));
        @(posedge clk);
        #1;
        check_eq("burst_decoded", 32'(sb.size()), 32'(0));

        // Saturate the FIFO with 0xA5 while transmitting.
        a_if.s_valid = 1'b1; a_if.s_data = 8'hA5;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lvl_a == 4'd8) break;
        end
        check_eq("full_level", 32'(lvl_a), 32'(8));
        check_eq("full_ready", 32'(a_if.s_ready), 32'(0));
        acc = 0; minl = 8;
        repeat (300) begin
            @(negedge clk);
            if (a_if.s_ready) acc++;
            if (int'(lvl_a) < minl) minl = int'(lvl_a);
        end
        check_eq("full_accept_per_frame", 32'(acc), 32'(3));
        check_eq("full_level_min", 32'(minl), 32'(7));
        @(posedge clk);
        #1;
        a_if.s_valid = 1'b0;
        wait_idle(0, 1500, "full_drain_idle");
        check_eq("full_decoded", 32'(sb.size()), 32'(0));

        // Push on the serializer's pop edge with one byte queued.
        starts.delete();
        push_byte(0, 8'h5A, n);
        push_byte(0, 8'h7E, m);
        check_eq("simul_same_edge", 32'(m - n), 32'(1));
        @(negedge clk);
        check_eq("simul_level", 32'(lvl_a), 32'(1));
        check_eq("simul_tx_start", 32'(tx_a), 32'(0));
        wait_idle(0, 400, "simul_idle");
        check_eq("simul_frames", 32'(starts.size()), 32'(2));
        if (starts.size() == 2)
            check_eq("simul_gap", 32'(starts[1] - starts[0]), 32'(100));
        check_eq("simul_decoded", 32'(sb.size()), 32'(0));

        // Two stop bits on instance B, second byte queued mid-frame.
        push_byte(1, 8'hFF, n);
        fork
            check_frame(1, 8'hFF, n, 2);
            begin
                repeat (20) @(posedge clk);
                #1;
                push_byte(1, 8'h81, m);
            end
        join
        check_eq("b_second_start", 32'(tx_b), 32'(0));
        check_frame(1, 8'h81, n + 110, 2);
        wait_idle(1, 300, "b_idle");

        // Reset in the middle of a 0x3C frame with three bytes queued.
        push_byte(0, 8'h3C, n);
        push_byte(0, 8'h11, m);
        push_byte(0, 8'h22, m);
        push_byte(0, 8'h33, m);
        while (cyc < n + 35) @(negedge clk);
        check_eq("midrst_pre_level", 32'(lvl_a), 32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tx", 32'(tx_a), 32'(1));
        check_eq("midrst_level", 32'(lvl_a), 32'(0));
        check_eq("midrst_ready", 32'(a_if.s_ready), 32'(1));
        check_eq("midrst_busy", 32'(busy_a), 32'(0));
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lows = 0; bhigh = 0;
        repeat (200) begin
            @(negedge clk);
            if (!tx_a)  lows++;
            if (busy_a) bhigh++;
        end
        check_eq("postrst_tx_low_cycles", 32'(lows), 32'(0));
        check_eq("postrst_busy_cycles", 32'(bhigh), 32'(0));
        check_eq("postrst_decoded", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
